// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // A one-bit adder still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int W = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/full_adder.sv
// Combinational one-bit full adder used as the serial adder's datapath slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, with valid/ready on both operand and result sides.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   sum_sh_q, sum_sh_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = W'({fa_s, sum_sh_q} >> 1);
        carry_d  = fa_c;
        if (cnt_q == LAST) begin
          // The final slice is the MSB: publish the result on this same edge.
          sum_d   = sum_sh_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.W(W)) bus ();

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain integer addition, sum and carry are the low W+1 bits.
  function automatic logic [W:0] refSum(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic cv);
    longint t;
    t = longint'(av) + longint'(bv) + longint'(cv);
    return t[W:0];
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic refOvf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic cv);
    longint half, sa, sb, r;
    half = longint'(1) << (W - 1);
    sa = longint'(av);
    sb = longint'(bv);
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    r = sa + sb + longint'(cv);
    return (r >= half) || (r < -half);
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full operation; caller is just after a rising edge with the DUT in IDLE.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input int stall, input bit busyValid);
    logic [W:0] expv;
    int         lat;
    bit         seen;
    expv = refSum(av, bv, cv);
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    if (busyValid) begin
      bus.a = ~av;
      bus.b = W'($urandom);
      bus.cin = ~cv;
    end else begin
      bus.in_valid = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.cin = 1'($urandom);
    end
    lat = 0;
    seen = 0;
    for (int k = 1; k <= W + 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (bus.out_valid) seen = 1;
      checkOutput("busy_in_ready", 64'(bus.in_ready), 64'(0));
    end
    if (!seen) begin
      checkOutput("done_timeout", 64'(0), 64'(1));
    end else begin
      checkOutput("latency", 64'(lat), 64'(W));
    end
    checkOutput("sum", 64'(bus.sum), 64'(expv[W-1:0]));
    checkOutput("cout", 64'(bus.cout), 64'(expv[W]));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ovf", 64'(bus.ovf), 64'(refOvf(av, bv, cv)));
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_out_valid", 64'(bus.out_valid), 64'(1));
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'(0));
      checkOutput("stall_sum", 64'({bus.cout, bus.sum}), 64'(expv));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ret_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("ret_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("ret_sum_held", 64'({bus.cout, bus.sum}), 64'(expv));
  endtask

  // Accept an operand set, then pull reset two clocks into the run.
  task automatic resetMidRun(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.a = av;
    bus.b = bv;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_sum", 64'(bus.sum), 64'(0));
    checkOutput("rst_cout", 64'(bus.cout), 64'(0));
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("rel_out_valid", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_sum", 64'(bus.sum), 64'(0));
    checkOutput("reset_cout", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("reset_ovf", 64'(bus.ovf), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(W'(4'b0011), W'(4'b0101), 1'b0, 0, 1'b0);
    applyStimulus(W'(4'hF), W'(4'h1), 1'b0, 0, 1'b0);
    applyStimulus(W'(4'hF), W'(4'hF), 1'b1, 0, 1'b0);
    applyStimulus(W'(4'h6), W'(4'h7), 1'b0, 3, 1'b0);
    applyStimulus(W'(4'h5), W'(4'hA), 1'b1, 0, 1'b1);
    applyStimulus(W'(4'h9), W'(4'h4), 1'b0, 0, 1'b0);
    resetMidRun(W'(4'h2), W'(4'h3));
    applyStimulus(W'(1), W'(2), 1'b0, 0, 1'b0);
    applyStimulus(W'(4'b0111), W'(4'b0001), 1'b0, 0, 1'b0);
    applyStimulus(W'(4'b1111), W'(4'b0001), 1'b0, 0, 1'b0);
    applyStimulus(W'(4'b1000), W'(4'b1000), 1'b0, 1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
